// File: rtl/eeprom_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : eeprom_arb_pkg                                          |
// | Brief    : Shared types and constants for the EEPROM save-RAM      |
// |            arbiter and its autosave timer.                         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package eeprom_arb_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    EE_HOLD = 3'd3,
    H_ACK   = 3'd4
  } arb_state_t;

  // Owner of the current or most recent RAM grant.
  typedef enum logic {
    GNT_EE   = 1'b0,
    GNT_HOST = 1'b1
  } grant_t;

  // Width of the autosave idle counter (AUTOSAVE_MS must fit in it).
  localparam int unsigned c_as_cnt_w = 16;

endpackage
`default_nettype wire

// File: rtl/eeprom_autosave_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : eeprom_autosave_timer                                   |
// | Brief    : Counts idle milliseconds while unsaved EEPROM data is   |
// |            pending and emits one save_req pulse at AUTOSAVE_MS.    |
// |            Only built when EEPROM_AUTOSAVE_EN is defined.          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module eeprom_autosave_timer #(
  parameter int unsigned AUTOSAVE_MS = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dirty,
  input  logic ee_wr,
  input  logic tick_ms,
  output logic save_req
);
  import eeprom_arb_pkg::*;

  localparam logic [c_as_cnt_w-1:0] c_limit = c_as_cnt_w'(AUTOSAVE_MS);

  logic [c_as_cnt_w-1:0] cnt_q, cnt_d;
  logic                  save_req_q, save_req_d;

  // Next count: restart on a fresh write or when clean, saturate at the limit.
  always_comb begin
    cnt_d      = cnt_q;
    save_req_d = 1'b0;
    if (!dirty || ee_wr) begin
      cnt_d = '0;
    end else if (tick_ms && (cnt_q != c_limit)) begin
      cnt_d      = cnt_q + 1'b1;
      save_req_d = (cnt_q == (c_limit - 1'b1));
    end
  end

  // Counter and request pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      save_req_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      save_req_q <= save_req_d;
    end
  end

  assign save_req = save_req_q;

endmodule
`default_nettype wire

// File: rtl/eeprom_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : eeprom_ram_arbiter                                      |
// | Brief    : Shares the single-port save RAM between the EEPROM      |
// |            model and the host save/load port; tracks unsaved       |
// |            EEPROM writes. Define EEPROM_AUTOSAVE_EN to build the   |
// |            idle autosave request timer.                            |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module eeprom_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned AUTOSAVE_MS = 500
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] ee_addr,
  input  logic                  ee_read,
  input  logic                  ee_write,
  input  logic [7:0]            ee_wdata,
  output logic [7:0]            ee_rdata,
  output logic                  ee_done,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [7:0]            host_wdata,
  output logic [7:0]            host_rdata,
  output logic                  host_ack,
  input  logic                  host_lock,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata,
  input  logic                  tick_ms,
  input  logic                  dirty_clr,
  output logic                  dirty,
  output logic                  save_req
);
  import eeprom_arb_pkg::*;

  arb_state_t            state_q, state_d;
  grant_t                gnt_q, gnt_d;
  grant_t                last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            ee_rdata_q, ee_rdata_d;
  logic [7:0]            host_rdata_q, host_rdata_d;
  logic                  dirty_q, dirty_d;

  logic                  w_ee_req;
  logic                  w_pick_ee;
  logic                  w_pick_host;
  logic                  w_ee_commit;

  // ee_done is only ever high in EE_HOLD, so in IDLE any raised request is new.
  assign w_ee_req    = ee_read | ee_write;
  // Lock shuts the EEPROM out; on contention the side not granted last wins.
  assign w_pick_ee   = !host_lock && w_ee_req && (!host_req || (last_q == GNT_HOST));
  assign w_pick_host = host_req && !w_pick_ee;
  assign w_ee_commit = mem_we && (gnt_q == GNT_EE);

  // Access sequencer: grant, issue, optional capture, then completion handshake.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ee_rdata_d   = ee_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      IDLE: begin
        if (w_pick_ee) begin
          gnt_d   = GNT_EE;
          last_d  = GNT_EE;
          we_d    = !ee_read;          // read wins when both are held
          addr_d  = ee_addr;
          wdata_d = ee_wdata;
          state_d = ISSUE;
        end else if (w_pick_host) begin
          gnt_d   = GNT_HOST;
          last_d  = GNT_HOST;
          we_d    = host_we;
          addr_d  = host_addr;
          wdata_d = host_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!we_q) begin
          state_d = CAPTURE;
        end else begin
          state_d = (gnt_q == GNT_EE) ? EE_HOLD : H_ACK;
        end
      end
      CAPTURE: begin
        if (gnt_q == GNT_EE) begin
          ee_rdata_d = mem_rdata;
          state_d    = EE_HOLD;
        end else begin
          host_rdata_d = mem_rdata;
          state_d      = H_ACK;
        end
      end
      EE_HOLD: begin
        if (!ee_read && !ee_write) begin
          state_d = IDLE;
        end
      end
      H_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Dirty flag: an EEPROM commit in the same cycle as a clear keeps it set.
  always_comb begin
    dirty_d = w_ee_commit || (dirty_q && !dirty_clr);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_HOST;
      last_q       <= GNT_HOST;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ee_rdata_q   <= '0;
      host_rdata_q <= '0;
      dirty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ee_rdata_q   <= ee_rdata_d;
      host_rdata_q <= host_rdata_d;
      dirty_q      <= dirty_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = (state_q == ISSUE) && we_q;
  assign ee_done    = (state_q == EE_HOLD);
  assign host_ack   = (state_q == H_ACK);
  assign ee_rdata   = ee_rdata_q;
  assign host_rdata = host_rdata_q;
  assign dirty      = dirty_q;

`ifdef EEPROM_AUTOSAVE_EN
  eeprom_autosave_timer #(
    .AUTOSAVE_MS (AUTOSAVE_MS)
  ) u_autosave (
    .clk      (clk),
    .reset_n  (reset_n),
    .dirty    (dirty_q),
    .ee_wr    (w_ee_commit),
    .tick_ms  (tick_ms),
    .save_req (save_req)
  );
`else
  logic unused_tick_ms;
  assign unused_tick_ms = tick_ms;
  assign save_req       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eeprom_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_eeprom_ram_arbiter                                   |
// | Brief    : Self-checking bench for eeprom_ram_arbiter with a       |
// |            transaction-level reference model and a 1-cycle RAM.    |
// |            Autosave expectations follow EEPROM_AUTOSAVE_EN.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_eeprom_ram_arbiter;

  localparam int AW    = 15;
  localparam int AS_MS = 3;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] ee_addr;
  logic          ee_read;
  logic          ee_write;
  logic [7:0]    ee_wdata;
  logic [7:0]    ee_rdata;
  logic          ee_done;
  logic [AW-1:0] host_addr;
  logic          host_req;
  logic          host_we;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          host_ack;
  logic          host_lock;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          tick_ms;
  logic          dirty_clr;
  logic          dirty;
  logic          save_req;

  eeprom_ram_arbiter #(
    .ADDR_WIDTH  (AW),
    .AUTOSAVE_MS (AS_MS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ee_addr    (ee_addr),
    .ee_read    (ee_read),
    .ee_write   (ee_write),
    .ee_wdata   (ee_wdata),
    .ee_rdata   (ee_rdata),
    .ee_done    (ee_done),
    .host_addr  (host_addr),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .host_lock  (host_lock),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .tick_ms    (tick_ms),
    .dirty_clr  (dirty_clr),
    .dirty      (dirty),
    .save_req   (save_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Save RAM: single port, one-cycle synchronous read.
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state.
  logic [7:0]    ref_mem [0:32767];
  logic [AW-1:0] pool [16];
  bit            exp_dirty;
  bit            last_ee;
  int            as_cnt;
  int            exp_pulses;

  // Observation counters.
  int            we_count;
  int            sr_count;
  int            done_cycles;
  logic [AW-1:0] we_addr_seen;
  logic [7:0]    we_data_seen;

  int n_checks;
  int n_errors;

  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      we_addr_seen = mem_addr;
      we_data_seen = mem_wdata;
    end
    if (save_req) sr_count++;
    if (ee_done) done_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {27'd0, ee_done, host_ack, mem_we, dirty, save_req}, 32'd0);
    check({tag, "_mem_addr"}, {17'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_rdata"}, {16'd0, ee_rdata, host_rdata}, 32'd0);
  endtask

  // One EEPROM access from IDLE; rd with also_wr models both lines held.
  task automatic ee_op(input bit rd, input bit also_wr, input logic [AW-1:0] a,
                       input logic [7:0] d, input int hold, input bit collide);
    int n;
    int w0;
    logic [7:0] held;
    ee_addr  = a;
    ee_wdata = d;
    ee_read  = rd;
    ee_write = rd ? also_wr : 1'b1;
    w0 = we_count;
    n  = 0;
    while (!ee_done && n < 20) begin
      @(posedge clk); #1;
      dirty_clr = collide && (n == 0);
      @(negedge clk);
      n++;
    end
    dirty_clr = 1'b0;
    check("ee_latency", n, rd ? 3 : 2);
    check("ee_we_count", we_count - w0, rd ? 0 : 1);
    last_ee = 1'b1;
    if (rd) begin
      check("ee_rdata", {24'd0, ee_rdata}, {24'd0, ref_mem[a]});
    end else begin
      ref_mem[a] = d;
      exp_dirty  = 1'b1;
      as_cnt     = 0;
      check("ee_we_addr", {17'd0, we_addr_seen}, {17'd0, a});
      check("ee_we_data", {24'd0, we_data_seen}, {24'd0, d});
      check("ee_ram", {24'd0, ram[a]}, {24'd0, d});
    end
    check("ee_dirty", {31'd0, dirty}, {31'd0, exp_dirty});
    held = ee_rdata;
    w0   = we_count;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("ee_done_held", {31'd0, ee_done}, 32'd1);
    end
    if (hold > 0) begin
      check("ee_hold_no_access", we_count - w0, 0);
      check("ee_hold_rdata", {24'd0, ee_rdata}, {24'd0, held});
    end
    @(posedge clk); #1;
    ee_read  = 1'b0;
    ee_write = 1'b0;
    @(negedge clk);
    check("ee_done_release", {31'd0, ee_done}, 32'd1);
    @(negedge clk);
    check("ee_done_fall", {31'd0, ee_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  // One host access from IDLE (other requester may be locked out).
  task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d);
    int n;
    int w0;
    host_addr  = a;
    host_we    = we;
    host_wdata = d;
    host_req   = 1'b1;
    w0 = we_count;
    n  = 0;
    while (!host_ack && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    check("host_latency", n, we ? 2 : 3);
    check("host_we_count", we_count - w0, we ? 1 : 0);
    last_ee = 1'b0;
    if (we) begin
      ref_mem[a] = d;
      check("host_ram", {24'd0, ram[a]}, {24'd0, d});
    end else begin
      check("host_rdata", {24'd0, host_rdata}, {24'd0, ref_mem[a]});
    end
    check("host_dirty", {31'd0, dirty}, {31'd0, exp_dirty});
    @(posedge clk); #1;
    host_req = 1'b0;
    @(negedge clk);
    check("host_ack_pulse", {31'd0, host_ack}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clr_pulse();
    dirty_clr = 1'b1;
    @(posedge clk); #1;
    dirty_clr = 1'b0;
    exp_dirty = 1'b0;
    as_cnt    = 0;
    @(negedge clk);
    check("clr_dirty", {31'd0, dirty}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    tick_ms = 1'b1;
    @(posedge clk); #1;
    tick_ms = 1'b0;
`ifdef EEPROM_AUTOSAVE_EN
    if (exp_dirty && as_cnt < AS_MS) begin
      as_cnt++;
      if (as_cnt == AS_MS) exp_pulses++;
    end
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int       k;
    int       first_ee;
    int       order[4];
    int       n_done;
    int       cyc;
    int       hi;
    int       d0;
    int       w0;
    bit       drop_ee;
    bit       rearm;
    bit       next_h;
    logic [AW-1:0] a;
    logic [7:0]    d;

    n_checks = 0; n_errors = 0;
    we_count = 0; sr_count = 0; done_cycles = 0;
    reset_n = 1'b0;
    ee_addr = '0; ee_read = 1'b0; ee_write = 1'b0; ee_wdata = '0;
    host_addr = '0; host_req = 1'b0; host_we = 1'b0; host_wdata = '0;
    host_lock = 1'b0; tick_ms = 1'b0; dirty_clr = 1'b0;
    exp_dirty = 1'b0; last_ee = 1'b0; as_cnt = 0; exp_pulses = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Address pool with spec corners, preloaded through the host port.
    pool[0] = '0;
    pool[1] = 15'h7FFF;
    pool[2] = 15'h1234;
    for (int i = 3; i < 16; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 16; i++) host_op(1'b1, pool[i], (i == 1) ? 8'h3C : 8'($urandom));

    // EEPROM write then long-held read of the top address.
    ee_op(1'b0, 1'b0, 15'h1234, 8'hA5, 3, 1'b0);
    ee_op(1'b1, 1'b0, 15'h7FFF, 8'h00, 20, 1'b0);
    check("ee_read_7fff", {24'd0, ee_rdata}, 32'h3C);

    // Continuous contention: grants must alternate, starting opposite the last grant.
    first_ee = last_ee ? 0 : 1;
    n_done = 0; cyc = 0; drop_ee = 1'b0; rearm = 1'b0; hi = 4; next_h = 1'b0;
    ee_addr = pool[3]; ee_read = 1'b1; ee_write = 1'b0;
    host_addr = pool[hi]; host_we = 1'b0; host_req = 1'b1;
    while (n_done < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ee_done && ee_read && n_done < 4) begin
        check("arb_ee_rdata", {24'd0, ee_rdata}, {24'd0, ref_mem[ee_addr]});
        order[n_done] = 1; n_done++; drop_ee = 1'b1; last_ee = 1'b1;
      end
      if (host_ack && n_done < 4) begin
        check("arb_host_rdata", {24'd0, host_rdata}, {24'd0, ref_mem[host_addr]});
        order[n_done] = 0; n_done++; next_h = 1'b1; last_ee = 1'b0;
      end
      @(posedge clk); #1;
      if (next_h) begin hi++; host_addr = pool[hi % 16]; next_h = 1'b0; end
      if (n_done >= 4) begin
        host_req = 1'b0; ee_read = 1'b0;
      end else if (drop_ee) begin
        ee_read = 1'b0; drop_ee = 1'b0; rearm = 1'b1;
      end else if (rearm) begin
        ee_addr = pool[(hi + 7) % 16]; ee_read = 1'b1; rearm = 1'b0;
      end
    end
    check("arb_completions", n_done, 4);
    for (int i = 0; i < 4; i++) check("arb_order", order[i], (i % 2 == 0) ? first_ee : 1 - first_ee);
    @(negedge clk);
    @(negedge clk);
    check("arb_idle", {30'd0, ee_done, host_ack}, 32'd0);
    @(posedge clk); #1;

    // Clear colliding with an EEPROM commit; host write leaves dirty alone.
    ee_op(1'b0, 1'b0, pool[5], 8'h11, 0, 1'b0);
    clr_pulse();
    ee_op(1'b0, 1'b0, pool[6], 8'h22, 0, 1'b1);
    host_op(1'b1, pool[7], 8'h55);

    // Randomised mixed traffic.
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 5);
      a = pool[$urandom_range(0, 15)];
      d = 8'($urandom);
      case (k)
        0:       ee_op(1'b0, 1'b0, a, d, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        1:       ee_op(1'b1, $urandom_range(0, 1) == 1, a, d, $urandom_range(0, 3), 1'b0);
        2:       host_op(1'b1, a, d);
        3:       host_op(1'b0, a, d);
        4:       clr_pulse();
        default: host_op(1'b0, a, d);
      endcase
    end

    // Host lock: EEPROM write stalls behind three host writes.
    host_lock = 1'b1;
    ee_addr = pool[8]; ee_wdata = 8'h6E; ee_read = 1'b0; ee_write = 1'b1;
    d0 = done_cycles; w0 = we_count;
    for (int i = 0; i < 3; i++) host_op(1'b1, pool[9 + i], 8'($urandom));
    check("lock_ee_stalled", done_cycles - d0, 0);
    check("lock_we_count", we_count - w0, 3);
    host_lock = 1'b0;
    ee_op(1'b0, 1'b0, pool[8], 8'h6E, 1, 1'b0);

    // Autosave: a write after two ticks restarts the idle count.
    sr_count = 0; exp_pulses = 0;
    ee_op(1'b0, 1'b0, pool[2], 8'h77, 0, 1'b0);
    tick(); tick();
    ee_op(1'b0, 1'b0, pool[2], 8'h78, 0, 1'b0);
    tick(); tick();
    check("autosave_restart", sr_count, 0);
    tick();
    check("autosave_pulse", sr_count, exp_pulses);
    tick(); tick(); tick();
    check("autosave_no_repeat", sr_count, exp_pulses);
    clr_pulse();
    tick(); tick(); tick(); tick();
    check("autosave_clean", sr_count, exp_pulses);

    // Reset in CAPTURE, request still held afterwards.
    ee_addr = pool[1]; ee_read = 1'b1; ee_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midread_reset");
    exp_dirty = 1'b0; last_ee = 1'b0; as_cnt = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ee_op(1'b1, 1'b0, pool[1], 8'h00, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
